// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and Booth decode constants.
package alu_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        EVAL  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } booth_state_t;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/iter_counter.sv
// iter_counter: loadable down-counter that saturates at zero and flags count==1.
module iter_counter #(
    parameter int cnt_w = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [cnt_w-1:0] load_value,
    input  logic             dec,
    output logic [cnt_w-1:0] count,
    output logic             last
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end
    assign last = count == cnt_w'(1);
endmodule

// File: rtl/booth_ctrl.sv
// booth_ctrl: radix-2 Booth sequencer driving the A/Q/M load, add/sub and shift enables.
module booth_ctrl
    import alu_pkg::*;
#(
    parameter int width = 8,
    parameter int cnt_w = $clog2(width + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q0,
    input  logic             q_m1,
    output logic             load_m,
    output logic             load_q,
    output logic             clear_a,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [cnt_w-1:0] count
);
    booth_state_t state, state_nxt;
    logic         last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? INIT : IDLE;
            INIT:    state_nxt = EVAL;
            EVAL:    state_nxt = {q0, q_m1} == BOOTH_ADD ? ADD :
                                 {q0, q_m1} == BOOTH_SUB ? SUB : SHIFT;
            ADD,
            SUB:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? DONE : EVAL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // Loading on the accepting edge makes count already read width during INIT.
    iter_counter #(.cnt_w(cnt_w)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .load       (state == IDLE && start),
        .load_value (cnt_w'(width)),
        .dec        (state == SHIFT),
        .count      (count),
        .last       (last)
    );
    assign load_m   = state == INIT;
    assign load_q   = state == INIT;
    assign clear_a  = state == INIT;
    assign add_en   = state == ADD;
    assign sub_en   = state == SUB;
    assign shift_en = state == SHIFT;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: random and directed Booth runs checked cycle-by-cycle against a sequence model,
// with a behavioural A/Q/M datapath whose final product is checked at done.
module tb_booth_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       q0, q_m1;
    logic       load_m, load_q, clear_a, add_en, sub_en, shift_en, busy, done;
    logic [3:0] count;
    logic [7:0] a_r, q_r, m_r, mult, mcand, cur_mq, cur_mm;
    logic       qm1_r;
    logic [11:0] exp_q[$];
    int         vecs = 0, errs = 0;
    int         n_add = 0, n_sub = 0, n_shift = 0;

    always #5 clk = ~clk;

    booth_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .q0       (q0),
        .q_m1     (q_m1),
        .load_m   (load_m),
        .load_q   (load_q),
        .clear_a  (clear_a),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // Behavioural A/Q/M registers reacting to the controller's enables.
    assign q0   = q_r[0];
    assign q_m1 = qm1_r;
    always @(posedge clk) begin
        if (load_q) q_r <= mult;
        if (load_m) m_r <= mcand;
        if (clear_a) begin
            a_r   <= 8'h00;
            qm1_r <= 1'b0;
        end
        if (add_en) a_r <= a_r + m_r;
        if (sub_en) a_r <= a_r - m_r;
        if (shift_en) {a_r, q_r, qm1_r} <= {a_r[7], a_r, q_r};
    end

    function automatic logic [11:0] got_vec();
        return {load_m, load_q, clear_a, add_en, sub_en, shift_en, busy, done, count};
    endfunction

    // Expected per-cycle outputs from INIT through the first IDLE cycle after DONE.
    function automatic void push_run(input logic [7:0] mq);
        logic [3:0] c = 4'd8;
        logic       prev = 1'b0;
        exp_q.push_back({6'b111000, 2'b10, 4'd8});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({6'b000000, 2'b10, c});
            if (!mq[i] && prev) exp_q.push_back({6'b000100, 2'b10, c});
            if (mq[i] && !prev) exp_q.push_back({6'b000010, 2'b10, c});
            exp_q.push_back({6'b000001, 2'b10, c});
            c = c - 4'd1;
            prev = mq[i];
        end
        exp_q.push_back({6'b000000, 2'b11, 4'd0});
        exp_q.push_back(12'h000);
    endfunction

    function automatic void chk(input string name, input int got, input int want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            logic [11:0] e, g;
            logic signed [15:0] want;
            g = got_vec();
            vecs++;
            if ($countones({add_en, sub_en, shift_en, load_m | load_q | clear_a}) > 1 || count > 4'd8) begin
                errs++;
                $display("FAIL exclusivity outputs=%b count=%0d at %0t", g, count, $time);
            end
            n_add   += int'(add_en);
            n_sub   += int'(sub_en);
            n_shift += int'(shift_en);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vecs++;
                if (g !== e) begin
                    errs++;
                    $display("FAIL seq got %b want %b at %0t", g, e, $time);
                end
                if (e[4]) begin
                    want = $signed(cur_mm) * $signed(cur_mq);
                    vecs++;
                    if ({a_r, q_r} !== want) begin
                        errs++;
                        $display("FAIL product mq=%h mm=%h got %h want %h", cur_mq, cur_mm, {a_r, q_r}, want);
                    end
                end
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        vecs++;
        if (exp_q.size() > 0) begin
            errs++;
            $display("FAIL timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [7:0] mq, input logic [7:0] mm, input bit hold);
        cur_mq = mq;
        cur_mm = mm;
        mult   = mq;
        mcand  = mm;
        n_add = 0; n_sub = 0; n_shift = 0;
        push_run(mq);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        wait_empty();
    endtask

    initial begin
        logic [7:0] r;
        mult = 8'h00;
        mcand = 8'h00;
        push_run(8'h00); chk("len_q00", exp_q.size(), 19); exp_q.delete();
        push_run(8'h55); chk("len_q55", exp_q.size(), 27); exp_q.delete();
        push_run(8'hFF); chk("len_qff", exp_q.size(), 20); exp_q.delete();
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(got_vec()), 0);
        #1 reset = 1'b1;
        run(8'h00, 8'h37, 0);
        chk("q00_shifts", n_shift, 8);
        chk("q00_addsub", n_add + n_sub, 0);
        run(8'h55, 8'h13, 0);
        chk("q55_adds", n_add, 4);
        chk("q55_subs", n_sub, 4);
        run(8'hFF, 8'hE9, 0);
        chk("qff_subs", n_sub, 1);
        chk("qff_adds", n_add, 0);
        run(8'h00, 8'h21, 1);
        run(8'h3C, 8'hA5, 0);
        // Abort a Q=0x55 run mid-way through its third SHIFT cycle.
        cur_mq = 8'h55; cur_mm = 8'h4B; mult = 8'h55; mcand = 8'h4B;
        push_run(8'h55);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("third_shift", int'(shift_en), 1);
        #1 reset = 1'b0;
        exp_q.delete();
        #1 chk("async_reset", int'(got_vec()), 0);
        @(negedge clk);
        chk("reset_hold", int'(got_vec()), 0);
        #1 reset = 1'b1;
        run(8'h55, 8'h4B, 0);
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom_range(0, 255));
            if (r == 8'h80) r = 8'h7F;
            run(8'($urandom_range(0, 255)), r, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for radix-2 Booth multiplication in the ALU. It sits directly upstream of the A, Q and M shift registers and the adder/subtractor. It accepts a start request and observes the two Booth bits {Q[0], Q[-1]}. It drives the per-cycle load, add/sub and arithmetic-right-shift enables until `width` iterations complete, then pulses `done`.

## Interface
- `width`, default 8: operand width; number of Booth iterations.
- `cnt_w`, default `$clog2(width+1)`: iteration counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset (the only reset).
- `start` input 1: request a multiplication. Sampled only in IDLE.
- `q0` input 1: current Q[0] from the Q register.
- `q_m1` input 1: current Q[-1] flag bit.
- `load_m` output 1: load multiplicand into M.
- `load_q` output 1: load multiplier into Q.
- `clear_a` output 1: load zero into A and clear Q[-1].
- `add_en` output 1: select A+M at the adder and load the result into A.
- `sub_en` output 1: select A−M at the adder and load the result into A.
- `shift_en` output 1: arithmetic right shift of {A, Q, Q[-1]}. A's MSB is re-injected into A's top bit.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse when the product is valid in {A, Q}.
- `count` output `cnt_w`: remaining iterations (debug).

## Operation
- States: IDLE, INIT, EVAL, ADD, SUB, SHIFT, DONE.
- IDLE:
  - All outputs 0; `count` = 0.
  - `start`=1 → INIT.
- INIT (1 cycle):
  - `load_m`=`load_q`=`clear_a`=1.
  - `count` ← `width`.
  - → EVAL.
- EVAL (1 cycle):
  - No enables asserted.
  - Decode {q0,q_m1}: 01 → ADD; 10 → SUB; 00 or 11 → SHIFT.
- ADD / SUB (1 cycle): `add_en` / `sub_en` =1 → SHIFT.
- SHIFT (1 cycle):
  - `shift_en`=1.
  - `count` ← `count`−1.
  - If `count`==1 before the decrement → DONE, else → EVAL.
- DONE (1 cycle): `done`=1, `busy`=1 → IDLE.
- Output exclusivity:
  - At most one of `add_en`, `sub_en`, `shift_en` is high in any cycle.
  - The INIT trio is never concurrent with any of them.
- All outputs are Moore outputs, decoded from registered state only. There is no combinational path from `q0`/`q_m1`/`start` to any output.
- `start` outside IDLE, including during DONE, is ignored. A new start is accepted only in IDLE.
- `count` never wraps. It reaches 0 exactly on the final SHIFT edge.

## Timing
- Reset (asynchronous, immediate on `reset`=0, from any state including mid-sequence):
  - State → IDLE.
  - Every output 0; `count` = 0.
  - No partial iteration resumes after release.
- Define `start` sampled high on rising edge E0:
  - INIT occupies cycle 1.
  - Each iteration takes 2 cycles (EVAL+SHIFT), or 3 cycles with ADD/SUB.
  - DONE occupies cycle 2·width+2+k, where k = number of ADD/SUB iterations (0…width).
- For `width`=8, latency to `done` is 18 to 26 cycles.
- `busy` rises the cycle after E0 and falls the cycle after DONE.
- `q0`/`q_m1` are read only in EVAL, one cycle after the preceding SHIFT or INIT edge, so register outputs are already settled.

## Structure
- Shared package `alu_pkg`:
  - `booth_state_t` enum (IDLE=0, INIT, EVAL, ADD, SUB, SHIFT, DONE; 3-bit encoding).
  - Booth decode localparams `BOOTH_ADD`=2'b01 and `BOOTH_SUB`=2'b10.
- Sub-module `iter_counter`:
  - Loadable down-counter with async active-low reset.
  - Ports: `load`, `load_value`, `dec`, `count`, `last` (`last` = `count`==1).
- FSM:
  - Next-state logic in a combinational block.
  - State register on the same async reset.
  - Output decode from state.

## Test plan
Bench models Q/Q[-1] behaviourally: load on `load_q`/`clear_a`, shift on `shift_en`. All cases use `width`=8.
- Multiplier Q=0x00, start at E0 → 8 `shift_en` pulses, zero `add_en`/`sub_en`, `done` in cycle 18, `busy` low in cycle 19.
- Q=0x55 → strict alternation of SUB, ADD ×4 each (8 arithmetic ops), `done` in cycle 26.
- Q=0xFF → exactly one `sub_en` (iteration 1), then 7 plain shifts, `done` in cycle 19.
- `start` held high through the whole run and through DONE (Q=0x00) → no restart. A second run begins only if `start` is high in IDLE; INIT follows next cycle with `count`=8.
- Assert `reset`=0 mid-cycle during the 3rd SHIFT (Q=0x55) → all outputs 0 before the next clock edge. After release plus `start`, the full sequence runs again with `count` reloaded to 8 and `done` in cycle 26.
- Every run → assertion that no two of {`add_en`, `sub_en`, `shift_en`, INIT group} are ever high together, and that `count` is never observed below 0 or above 8.
